// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
//
// Purpose:
//   Time-multiplexed driver for a common-anode style multi-digit 7-segment
//   display. A display register holds one nibble per digit. A slot counter
//   divides CLK so that each digit gets DIV clock cycles of on-time. On every
//   slot boundary (tick) the next digit is selected and the segment pattern,
//   digit select and decimal point are registered together. Optional
//   leading-zero blanking hides digits above the highest nonzero nibble.
//
// Parameters:
//   DIGITS   - number of multiplexed digits (1..16)
//   DIV      - CLK cycles per digit slot (>= 1)
//   DOT_MASK - one bit per digit, 1 = decimal point lit on that digit
//
// Ports:
//   CLK  in   1          system clock, all state on rising edge
//   RST  in   1          asynchronous active-high reset
//   DI   in   4*DIGITS   display value, nibble k drives digit k
//   WE   in   1          load DI into the display register
//   LZB  in   1          leading-zero blanking enable
//   DO   out  7          segment pattern gfedcba, active-low
//   SHF  out  DIGITS     digit select, active-low one-hot
//   DOT  out  1          decimal point, active-low
//
// Configuration:
//   SEG_SCAN_HEX_EN - when defined, nibbles 10..15 show A,b,C,d,E,F.
//                     When undefined they are blanked (all segments off),
//                     but they still count as nonzero for blanking.
// ---------------------------------------------------------------------------
module seg_scan_display #(
  parameter int                DIGITS   = 8,
  parameter int                DIV      = 200000,
  parameter logic [DIGITS-1:0] DOT_MASK = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DI,
  input  logic                  WE,
  input  logic                  LZB,
  output logic [6:0]            DO,
  output logic [DIGITS-1:0]     SHF,
  output logic                  DOT
);

  // Counter widths are clamped to one bit so DIV=1 / DIGITS=1 stay legal.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // State
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic [IDX_W-1:0]    idx_q,  idx_d;
  logic [6:0]          do_q,   do_d;
  logic [DIGITS-1:0]   shf_q,  shf_d;
  logic                dot_q,  dot_d;

  // Combinational helpers
  logic                tick;
  logic [3:0]          cur_nib;
  logic                cur_dot;
  logic [IDX_W-1:0]    hi_nz;
  logic [DIGITS-1:0]   shf_sel;
  logic                blank;

  // Active-low gfedcba decode of one nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
`ifdef SEG_SCAN_HEX_EN
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
`else
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg = SEG_BLANK;
`endif
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Slot counter, digit index and display register next-state.
  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    disp_d = WE ? DI : disp_q;
  end

  // Selects the current nibble and dot bit, builds the one-hot select and
  // finds the highest nonzero nibble. All of this reads disp_q, so a write
  // landing in the tick cycle is not seen until the following slot.
  always_comb begin
    cur_nib = 4'h0;
    cur_dot = 1'b0;
    hi_nz   = '0;
    shf_sel = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'h0) begin
        hi_nz = IDX_W'(k);
      end
      if (idx_q == IDX_W'(k)) begin
        cur_nib    = disp_q[4*k +: 4];
        cur_dot    = DOT_MASK[k];
        shf_sel[k] = 1'b0;
      end
    end
    // hi_nz stays 0 for an all-zero value, so digit 0 is never blanked.
    blank = LZB && (idx_q > hi_nz);
  end

  // Output registers only move on a tick so DO/SHF/DOT change together.
  always_comb begin
    do_d  = do_q;
    shf_d = shf_q;
    dot_d = dot_q;
    if (tick) begin
      do_d  = blank ? SEG_BLANK : seg_decode(cur_nib);
      shf_d = shf_sel;
      dot_d = ~cur_dot;
    end
  end

  // All state with asynchronous reset to a blanked, digit-0 restart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      do_q   <= SEG_BLANK;
      shf_q  <= '1;
      dot_q  <= 1'b1;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      do_q   <= do_d;
      shf_q  <= shf_d;
      dot_q  <= dot_d;
    end
  end

  assign DO  = do_q;
  assign SHF = shf_q;
  assign DOT = dot_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
//
// Self-checking bench for seg_scan_display with DIGITS=4, DIV=4 and
// DOT_MASK=4'b0100. Expected digit updates come from a small reference model
// and are queued when stimulus is applied, then popped and compared as the
// DUT produces each slot update.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int         DIGITS   = 4;
  localparam int         DIV      = 4;
  localparam logic [3:0] DOT_MASK = 4'b0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] DI  = 16'h0000;
  logic        WE  = 1'b0;
  logic        LZB = 1'b0;
  logic [6:0]  DO;
  logic [3:0]  SHF;
  logic        DOT;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] shf;
    logic       dot;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  seg_scan_display #(
    .DIGITS  (DIGITS),
    .DIV     (DIV),
    .DOT_MASK(DOT_MASK)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .DI (DI),
    .WE (WE),
    .LZB(LZB),
    .DO (DO),
    .SHF(SHF),
    .DOT(DOT)
  );

  // Reference segment table, active-low gfedcba.
  function automatic logic [6:0] model_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
`ifdef SEG_SCAN_HEX_EN
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
`endif
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected outputs when digit idx of value v is shown. A digit is blanked
  // when blanking is on, it is not digit 0 and it and all digits above it
  // are zero.
  function automatic exp_t model_digit(input logic [15:0] v, input int idx, input logic lzb);
    exp_t        r;
    logic [15:0] upper;
    logic [3:0]  mask;
    upper = v >> (4 * idx);
    mask  = DOT_MASK;
    r.seg = (lzb && idx != 0 && upper == 16'h0000) ? 7'b1111111 : model_seg(upper[3:0]);
    r.shf = ~(4'b0001 << idx);
    r.dot = ~mask[idx[1:0]];
    return r;
  endfunction

  // Pulse reset, then load value on the first edge after release. Returns
  // at the falling edge after that first edge; the first update follows on
  // the third rising edge from there.
  task automatic reset_and_load(input logic [15:0] value, input logic lzb);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    DI  = value;
    WE  = 1'b1;
    LZB = lzb;
    @(negedge CLK);
    WE  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (DO !== 7'b1111111) begin
      n_fail++;
      $display("[TB] FAIL reset_DO got %b expected %b", DO, 7'b1111111);
    end
    n_checks++;
    if (SHF !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL reset_SHF got %b expected %b", SHF, 4'b1111);
    end
    n_checks++;
    if (DOT !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_DOT got %b expected %b", DOT, 1'b1);
    end
  endtask

  // Scan a value for n_upd slots checking each update and that the outputs
  // hold through the rest of the slot.
  task automatic test_scan_pattern(input string name, input logic [15:0] value,
                                   input logic lzb, input int n_upd);
    exp_t e;
    exp_t got;
    $display("[TB] scenario %s value=%h lzb=%b", name, value, lzb);
    reset_and_load(value, lzb);
    for (int u = 0; u < n_upd; u++) begin
      sb.push_back(model_digit(value, u % DIGITS, lzb));
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int u = 0; u < n_upd; u++) begin
      e = sb.pop_front();
      n_checks++;
      if (DO !== e.seg) begin
        n_fail++;
        $display("[TB] FAIL %s_upd%0d_DO got %b expected %b", name, u, DO, e.seg);
      end
      n_checks++;
      if (SHF !== e.shf) begin
        n_fail++;
        $display("[TB] FAIL %s_upd%0d_SHF got %b expected %b", name, u, SHF, e.shf);
      end
      n_checks++;
      if (DOT !== e.dot) begin
        n_fail++;
        $display("[TB] FAIL %s_upd%0d_DOT got %b expected %b", name, u, DOT, e.dot);
      end
      repeat (3) @(posedge CLK);
      #1;
      got = {DO, SHF, DOT};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("[TB] FAIL %s_upd%0d_hold got %b expected %b", name, u, got, e);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  // Write landing in the tick cycle: that update shows the old nibble, the
  // next one the new value.
  task automatic test_back_to_back();
    exp_t e;
    $display("[TB] scenario back_to_back");
    reset_and_load(16'h1234, 1'b0);
    sb.push_back(model_digit(16'h1234, 0, 1'b0));
    sb.push_back(model_digit(16'h1234, 1, 1'b0));
    sb.push_back(model_digit(16'h9999, 2, 1'b0));
    repeat (3) @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (DO !== e.seg) begin
      n_fail++;
      $display("[TB] FAIL b2b_digit0_DO got %b expected %b", DO, e.seg);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    DI = 16'h9999;
    WE = 1'b1;
    @(posedge CLK);
    #1;
    WE = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (DO !== e.seg) begin
      n_fail++;
      $display("[TB] FAIL b2b_old_nibble_DO got %b expected %b", DO, e.seg);
    end
    n_checks++;
    if (SHF !== e.shf) begin
      n_fail++;
      $display("[TB] FAIL b2b_old_nibble_SHF got %b expected %b", SHF, e.shf);
    end
    repeat (4) @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (DO !== e.seg) begin
      n_fail++;
      $display("[TB] FAIL b2b_new_value_DO got %b expected %b", DO, e.seg);
    end
    n_checks++;
    if (DOT !== e.dot) begin
      n_fail++;
      $display("[TB] FAIL b2b_new_value_DOT got %b expected %b", DOT, e.dot);
    end
  endtask

  // Reset asserted between clock edges must blank at once, and the scan
  // must restart from digit 0.
  task automatic test_async_reset();
    exp_t e;
    $display("[TB] scenario async_reset");
    reset_and_load(16'h1234, 1'b0);
    repeat (3) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    n_checks++;
    if (DO !== 7'b1111111) begin
      n_fail++;
      $display("[TB] FAIL async_rst_DO got %b expected %b", DO, 7'b1111111);
    end
    n_checks++;
    if (SHF !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL async_rst_SHF got %b expected %b", SHF, 4'b1111);
    end
    n_checks++;
    if (DOT !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_rst_DOT got %b expected %b", DOT, 1'b1);
    end
    @(negedge CLK);
    RST = 1'b0;
    DI  = 16'h5678;
    WE  = 1'b1;
    sb.push_back(model_digit(16'h5678, 0, 1'b0));
    sb.push_back(model_digit(16'h5678, 1, 1'b0));
    @(negedge CLK);
    WE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (SHF !== e.shf) begin
      n_fail++;
      $display("[TB] FAIL async_restart_SHF got %b expected %b", SHF, e.shf);
    end
    n_checks++;
    if (DO !== e.seg) begin
      n_fail++;
      $display("[TB] FAIL async_restart_DO got %b expected %b", DO, e.seg);
    end
    repeat (4) @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_checks++;
    if ({DO, SHF} !== {e.seg, e.shf}) begin
      n_fail++;
      $display("[TB] FAIL async_second_digit got %b expected %b", {DO, SHF}, {e.seg, e.shf});
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_scan_pattern("scan_1234",   16'h1234, 1'b0, 5);
    test_scan_pattern("lzb_0070",    16'h0070, 1'b1, 4);
    test_scan_pattern("zero_lzb",    16'h0000, 1'b1, 4);
    test_scan_pattern("zero_nolzb",  16'h0000, 1'b0, 4);
    test_scan_pattern("hex_00af",    16'h00AF, 1'b0, 4);
    test_scan_pattern("lzb_hex_a05", 16'hA005, 1'b1, 4);
    test_scan_pattern("lzb_0300",    16'h0300, 1'b1, 4);
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
